// File: rtl/seq_divider_if.sv
// seq_divider_if: operand/control and result bus of the sequential divider.
interface seq_divider_if #(parameter int WIDTH = 8);
   logic             run;
   logic             load_divisor;
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic [WIDTH-1:0] divisor_val;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   modport master (
      output run, load_divisor, s,
      input  quotient, remainder, divisor_val, busy, done, div_by_zero
   );
   modport slave (
      input  run, load_divisor, s,
      output quotient, remainder, divisor_val, busy, done, div_by_zero
   );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per clock.
module seq_divider #(parameter int WIDTH = 8) (
   input  logic          clk_i,
   input  logic          reset_i,
   seq_divider_if.slave  bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;
   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, div_q, div_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH:0]   t, diff;
   assign t    = {rem_q, quo_q[WIDTH-1]};
   assign diff = t - {1'b0, div_q};
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      div_d   = div_q;
      dbz_d   = dbz_q;
      case (state_q)
         IDLE: begin
            if (bus.load_divisor) begin
               div_d = bus.s;
               quo_d = '0;
               rem_d = '0;
               dbz_d = 1'b0;
            end else if (bus.run) begin
               // a zero divisor skips the iterations and reports all-ones quotient
               quo_d   = (div_q != '0) ? bus.s : '1;
               rem_d   = (div_q != '0) ? '0 : bus.s;
               dbz_d   = (div_q == '0);
               cnt_d   = '0;
               state_d = (div_q != '0) ? DIVIDE : DONE;
            end
         end
         DIVIDE: begin
            rem_d   = diff[WIDTH] ? t[WIDTH-1:0] : diff[WIDTH-1:0];
            quo_d   = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : DIVIDE;
         end
         DONE:    state_d = bus.run ? DONE : IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         div_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         div_q   <= div_d;
         dbz_q   <= dbz_d;
      end
   end
   assign bus.quotient    = quo_q;
   assign bus.remainder   = rem_q;
   assign bus.divisor_val = div_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.busy        = (state_q == DIVIDE);
   assign bus.done        = (state_q == DONE);
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider against / and % arithmetic.
module tb_seq_divider;
   localparam int W = 8;
   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_fail = 0;
   logic [W-1:0] m_div;
   always #5 clk = ~clk;
   seq_divider_if #(.WIDTH(W)) bus ();
   seq_divider #(.WIDTH(W)) dut (.clk_i(clk), .reset_i(reset), .bus(bus));
   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic load(input logic [W-1:0] d);
      bus.s = d;
      bus.load_divisor = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.load_divisor = 1'b0;
      m_div = d;
      check("load_div", bus.divisor_val, d);
      check("load_dbz", bus.div_by_zero, 0);
      check("load_q", bus.quotient, 0);
      check("load_r", bus.remainder, 0);
   endtask
   task automatic run_op(input logic [W-1:0] a, input bit perturb, input bit hold);
      int eq, er, lim, edges;
      eq  = (m_div == 0) ? (1 << W) - 1 : int'(a) / int'(m_div);
      er  = (m_div == 0) ? int'(a) : int'(a) % int'(m_div);
      lim = (m_div == 0) ? 1 : W + 1;
      bus.s = a;
      bus.run = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.run = hold;
      edges = 1;
      check("busy_start", bus.busy, m_div != 0);
      while (!bus.done && edges < 3 * W) begin
         if (perturb) begin
            bus.s = W'($urandom);
            bus.load_divisor = 1'($urandom);
            bus.run = 1'($urandom);
         end
         @(negedge clk);
         edges++;
      end
      bus.run = hold;
      bus.load_divisor = 1'b0;
      check("latency", edges, lim);
      check("quotient", bus.quotient, eq);
      check("remainder", bus.remainder, er);
      check("dbz", bus.div_by_zero, m_div == 0);
      check("div_stable", bus.divisor_val, m_div);
      if (hold) begin
         repeat (20) begin
            @(negedge clk);
            check("hold_done", bus.done, 1);
            check("hold_q", bus.quotient, eq);
         end
         bus.run = 1'b0;
      end
      @(negedge clk);
      check("back_idle", bus.done, 0);
      check("kept_q", bus.quotient, eq);
   endtask
   initial begin
      reset = 1'b1;
      bus.run = 1'b0;
      bus.load_divisor = 1'b0;
      bus.s = '0;
      m_div = '0;
      #12;
      check("rst_q", bus.quotient, 0);
      check("rst_r", bus.remainder, 0);
      check("rst_div", bus.divisor_val, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_dbz", bus.div_by_zero, 0);
      @(negedge clk);
      reset = 1'b0;
      load(8'd7);   run_op(8'd200, 1'b0, 1'b0);
      load(8'd1);   run_op(8'd255, 1'b0, 1'b0);
      load(8'd255); run_op(8'd255, 1'b0, 1'b0);
      load(8'd9);   run_op(8'd5, 1'b0, 1'b0);
      load(8'd0);   run_op(8'h2A, 1'b0, 1'b0);
      load(8'd0);
      load(8'd7);   run_op(8'd200, 1'b0, 1'b1);
      bus.s = 8'h33;
      bus.run = 1'b1;
      bus.load_divisor = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.run = 1'b0;
      bus.load_divisor = 1'b0;
      m_div = 8'h33;
      check("same_edge_div", bus.divisor_val, 8'h33);
      check("same_edge_busy", bus.busy, 0);
      check("same_edge_done", bus.done, 0);
      load(8'd3);   run_op(8'd100, 1'b1, 1'b0);
      load(8'd5);
      bus.s = 8'h9A;
      bus.run = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.run = 1'b0;
      repeat (4) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("abort_q", bus.quotient, 0);
      check("abort_r", bus.remainder, 0);
      check("abort_div", bus.divisor_val, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      @(negedge clk);
      reset = 1'b0;
      m_div = '0;
      for (int i = 0; i < 300; i++) begin
         load(W'($urandom_range(0, 255)));
         run_op(W'($urandom), 1'(i % 4 == 0), 1'b0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
